// File: rtl/packet_receiver.sv
// packet_receiver: packet receiver that assembles HEAD/BODY/TAIL flits into a delivered summary.
//
// Optional feature macro: PKT_RX_TIMEOUT_EN enables the RECV idle watchdog.
// Without the macro there is no watchdog, RECV waits indefinitely and o_err_tmo is 0.
//
// Ports:
//   clk, reset_n        clock (rising edge), asynchronous active-low reset
//   i_flit              incoming flit (router_pkg::FLIT_t)
//   i_rec_req           upstream delivery request (informational; ack does not depend on it)
//   o_rec_ack           receiver accepts flits (IDLE and RECV)
//   o_pkt_valid         completed packet summary available (HOLD)
//   i_pkt_ready         consumer accepts the summary
//   o_pkt_xaddr/yaddr   head address of the delivered packet
//   o_pkt_len           body flit count
//   o_pkt_sum           modulo-2^16 sum of body data
//   o_pkt_addr_err      head address differs from {MY_X, MY_Y}
//   o_err_seq/ovf/tmo   one-cycle error pulses
//   o_pkt_count         delivered-packet counter

package router_pkg;
    typedef enum logic [1:0] {NONE = 2'd0, HEAD = 2'd1, BODY = 2'd2, TAIL = 2'd3} flit_type_t;
    typedef struct packed {
        logic       valid;
        flit_type_t flit_type;
        logic [7:0] xaddr;
        logic [7:0] yaddr;
        logic [15:0] data;
    } FLIT_t;
endpackage

module packet_receiver
    import router_pkg::*;
#(
    parameter int MY_X           = 3,
    parameter int MY_Y           = 3,
    parameter int MAX_BODY       = 8,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  FLIT_t                       i_flit,
    input  logic                        i_rec_req,
    output logic                        o_rec_ack,
    output logic                        o_pkt_valid,
    input  logic                        i_pkt_ready,
    output logic [7:0]                  o_pkt_xaddr,
    output logic [7:0]                  o_pkt_yaddr,
    output logic [$clog2(MAX_BODY):0]   o_pkt_len,
    output logic [15:0]                 o_pkt_sum,
    output logic                        o_pkt_addr_err,
    output logic                        o_err_seq,
    output logic                        o_err_ovf,
    output logic                        o_err_tmo,
    output logic [15:0]                 o_pkt_count
);
    localparam int LW = $clog2(MAX_BODY) + 1;

    typedef enum logic [1:0] {IDLE, RECV, HOLD} state_t;

    state_t         state_q, state_d;
    logic [7:0]     xaddr_q, xaddr_d, yaddr_q, yaddr_d;
    logic [LW-1:0]  len_q, len_d;
    logic [15:0]    sum_q, sum_d, count_q, count_d;
    logic           addr_err_q, addr_err_d;
    logic           err_seq_q, err_seq_d, err_ovf_q, err_ovf_d, err_tmo_q, err_tmo_d;
    logic           smp, start;
    logic           unused_ok;

`ifdef PKT_RX_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    logic [WW-1:0]  wdog_q, wdog_d;
    assign unused_ok = i_rec_req;
`else
    assign unused_ok = i_rec_req ^ (TIMEOUT_CYCLES == 0);
`endif

    assign o_rec_ack      = state_q != HOLD;
    assign o_pkt_valid    = state_q == HOLD;
    assign o_pkt_xaddr    = xaddr_q;
    assign o_pkt_yaddr    = yaddr_q;
    assign o_pkt_len      = len_q;
    assign o_pkt_sum      = sum_q;
    assign o_pkt_addr_err = addr_err_q;
    assign o_err_seq      = err_seq_q;
    assign o_err_ovf      = err_ovf_q;
    assign o_err_tmo      = err_tmo_q;
    assign o_pkt_count    = count_q;

    // Flits are only sampled while the receiver is acknowledging.
    assign smp = i_flit.valid && o_rec_ack;

    always_comb begin
        state_d    = state_q;
        xaddr_d    = xaddr_q;
        yaddr_d    = yaddr_q;
        len_d      = len_q;
        sum_d      = sum_q;
        count_d    = count_q;
        addr_err_d = addr_err_q;
        err_seq_d  = 1'b0;
        err_ovf_d  = 1'b0;
        err_tmo_d  = 1'b0;
        start      = 1'b0;
`ifdef PKT_RX_TIMEOUT_EN
        wdog_d     = wdog_q;
`endif
        case (state_q)
            IDLE: begin
                if (smp) begin
                    case (i_flit.flit_type)
                        HEAD:       start = 1'b1;
                        BODY, TAIL: err_seq_d = 1'b1;
                        default:    ;
                    endcase
                end
            end
            RECV: begin
                if (smp) begin
`ifdef PKT_RX_TIMEOUT_EN
                    wdog_d = '0;
`endif
                    case (i_flit.flit_type)
                        HEAD: begin
                            err_seq_d = 1'b1;
                            start     = 1'b1;
                        end
                        BODY: begin
                            if (len_q == LW'(MAX_BODY)) begin
                                err_ovf_d = 1'b1;
                                state_d   = IDLE;
                            end else begin
                                sum_d = sum_q + i_flit.data;
                                len_d = len_q + 1'b1;
                            end
                        end
                        TAIL:    state_d = HOLD;
                        default: ;
                    endcase
                end
`ifdef PKT_RX_TIMEOUT_EN
                // Watchdog fires on the cycle its count would reach TIMEOUT_CYCLES.
                else if (wdog_q == WW'(TIMEOUT_CYCLES - 1)) begin
                    err_tmo_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
`endif
            end
            HOLD: begin
                if (i_pkt_ready) begin
                    count_d = count_q + 16'd1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // A head (fresh or restarting) opens a new packet.
        if (start) begin
            xaddr_d    = i_flit.xaddr;
            yaddr_d    = i_flit.yaddr;
            len_d      = '0;
            sum_d      = '0;
            addr_err_d = (i_flit.xaddr != 8'(MY_X)) || (i_flit.yaddr != 8'(MY_Y));
            state_d    = RECV;
`ifdef PKT_RX_TIMEOUT_EN
            wdog_d     = '0;
`endif
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            xaddr_q    <= '0;
            yaddr_q    <= '0;
            len_q      <= '0;
            sum_q      <= '0;
            count_q    <= '0;
            addr_err_q <= 1'b0;
            err_seq_q  <= 1'b0;
            err_ovf_q  <= 1'b0;
            err_tmo_q  <= 1'b0;
`ifdef PKT_RX_TIMEOUT_EN
            wdog_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            xaddr_q    <= xaddr_d;
            yaddr_q    <= yaddr_d;
            len_q      <= len_d;
            sum_q      <= sum_d;
            count_q    <= count_d;
            addr_err_q <= addr_err_d;
            err_seq_q  <= err_seq_d;
            err_ovf_q  <= err_ovf_d;
            err_tmo_q  <= err_tmo_d;
`ifdef PKT_RX_TIMEOUT_EN
            wdog_q     <= wdog_d;
`endif
        end
    end
endmodule

// File: tb/tb_packet_receiver.sv
// tb_packet_receiver: directed and randomized checks of packet_receiver against a packet-level model.
module tb_packet_receiver;
    import router_pkg::*;

    localparam int MY_X = 3, MY_Y = 3, MAX_BODY = 8, TMO = 4;
    localparam int LW = $clog2(MAX_BODY) + 1;
`ifdef PKT_RX_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic          clk = 1'b0, reset_n = 1'b0;
    FLIT_t         flit;
    logic          rec_req, pkt_ready;
    logic          rec_ack, pkt_valid, addr_err, err_seq, err_ovf, err_tmo;
    logic [7:0]    pkt_x, pkt_y;
    logic [LW-1:0] pkt_len;
    logic [15:0]   pkt_sum, pkt_count;

    packet_receiver #(.MY_X(MY_X), .MY_Y(MY_Y), .MAX_BODY(MAX_BODY), .TIMEOUT_CYCLES(TMO)) u_dut (
        .clk(clk), .reset_n(reset_n), .i_flit(flit), .i_rec_req(rec_req), .o_rec_ack(rec_ack),
        .o_pkt_valid(pkt_valid), .i_pkt_ready(pkt_ready), .o_pkt_xaddr(pkt_x), .o_pkt_yaddr(pkt_y),
        .o_pkt_len(pkt_len), .o_pkt_sum(pkt_sum), .o_pkt_addr_err(addr_err), .o_err_seq(err_seq),
        .o_err_ovf(err_ovf), .o_err_tmo(err_tmo), .o_pkt_count(pkt_count)
    );

    always #5 clk = ~clk;

    int n_tests = 0, n_fail = 0;

    // Packet-level reference model: receiving/holding flags, body list, counters.
    bit         m_busy, m_hold, e_seq, e_ovf, e_tmo;
    logic [7:0] m_x, m_y;
    int         m_body[$];
    int         m_idle;
    logic [15:0] m_count;

    function automatic logic [15:0] m_sum();
        int s = 0;
        foreach (m_body[i]) s += m_body[i];
        return 16'(s % 65536);
    endfunction

    function automatic FLIT_t mk(logic v, flit_type_t t, logic [7:0] x, logic [7:0] y, logic [15:0] d);
        FLIT_t f;
        f.valid = v; f.flit_type = t; f.xaddr = x; f.yaddr = y; f.data = d;
        return f;
    endfunction

    function automatic FLIT_t head(logic [7:0] x, logic [7:0] y); return mk(1'b1, HEAD, x, y, 16'h0); endfunction
    function automatic FLIT_t body(logic [15:0] d); return mk(1'b1, BODY, 8'h0, 8'h0, d); endfunction
    function automatic FLIT_t tail(); return mk(1'b1, TAIL, 8'h0, 8'h0, 16'h0); endfunction
    function automatic FLIT_t idle(); return mk(1'b0, NONE, 8'h0, 8'h0, 16'h0); endfunction

    task automatic model_reset();
        m_busy = 0; m_hold = 0; e_seq = 0; e_ovf = 0; e_tmo = 0;
        m_x = 0; m_y = 0; m_body.delete(); m_idle = 0; m_count = 0;
    endtask

    task automatic model_step(input FLIT_t f, input logic rdy);
        e_seq = 0; e_ovf = 0; e_tmo = 0;
        if (m_hold) begin
            if (rdy) begin m_hold = 0; m_count = m_count + 16'd1; end
        end else if (f.valid) begin
            m_idle = 0;
            if (f.flit_type == HEAD) begin
                e_seq = m_busy; m_busy = 1; m_x = f.xaddr; m_y = f.yaddr; m_body.delete();
            end else if (f.flit_type != NONE && !m_busy) begin
                e_seq = 1;
            end else if (f.flit_type == BODY) begin
                if (m_body.size() == MAX_BODY) begin e_ovf = 1; m_busy = 0; end
                else m_body.push_back(int'(f.data));
            end else if (f.flit_type == TAIL) begin
                m_busy = 0; m_hold = 1;
            end
        end else if (m_busy) begin
            m_idle++;
            if (TMO_EN && m_idle == TMO) begin e_tmo = 1; m_busy = 0; end
        end
    endtask

    task automatic step(input FLIT_t f, input logic rdy);
        flit = f; pkt_ready = rdy; rec_req = f.valid;
        model_step(f, rdy);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        reset_n = 0; flit = idle(); pkt_ready = 0; rec_req = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++; if ({pkt_valid, addr_err, err_seq, err_ovf, err_tmo} !== 5'b0) begin n_fail++; $display("FAIL reset_flags got %b want 00000", {pkt_valid, addr_err, err_seq, err_ovf, err_tmo}); end
        n_tests++; if ({pkt_x, pkt_y, pkt_sum, pkt_count} !== 48'h0) begin n_fail++; $display("FAIL reset_data got %h want 0", {pkt_x, pkt_y, pkt_sum, pkt_count}); end
        n_tests++; if (pkt_len !== '0) begin n_fail++; $display("FAIL reset_len got %0d want 0", pkt_len); end
        reset_n = 1;
        n_tests++; if (rec_ack !== 1'b1) begin n_fail++; $display("FAIL reset_ack got %b want 1", rec_ack); end
    endtask

    task automatic test_basic();
        step(head(8'd3, 8'd3), 1'b1);
        step(body(16'h0001), 1'b1);
        step(body(16'h0002), 1'b1);
        step(tail(), 1'b1);
        n_tests++; if (pkt_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid got %b want 1", pkt_valid); end
        n_tests++; if (pkt_len !== LW'(2)) begin n_fail++; $display("FAIL basic_len got %0d want 2", pkt_len); end
        n_tests++; if (pkt_sum !== 16'h0003) begin n_fail++; $display("FAIL basic_sum got %h want 0003", pkt_sum); end
        n_tests++; if (addr_err !== 1'b0 || pkt_x !== 8'd3 || pkt_y !== 8'd3) begin n_fail++; $display("FAIL basic_addr got err=%b x=%0d y=%0d want 0 3 3", addr_err, pkt_x, pkt_y); end
        step(idle(), 1'b1);
        n_tests++; if (pkt_count !== 16'd1 || rec_ack !== 1'b1) begin n_fail++; $display("FAIL basic_count got %0d ack=%b want 1 1", pkt_count, rec_ack); end
    endtask

    task automatic test_wrap_addr_err();
        step(head(8'd1, 8'd2), 1'b0);
        step(body(16'hFFFF), 1'b0);
        step(body(16'h0002), 1'b0);
        step(tail(), 1'b0);
        n_tests++; if (pkt_sum !== 16'h0001) begin n_fail++; $display("FAIL wrap_sum got %h want 0001", pkt_sum); end
        n_tests++; if (addr_err !== 1'b1 || pkt_valid !== 1'b1) begin n_fail++; $display("FAIL wrap_addr_err got err=%b valid=%b want 1 1", addr_err, pkt_valid); end
        step(idle(), 1'b1);
        n_tests++; if (pkt_count !== 16'd2) begin n_fail++; $display("FAIL wrap_count got %0d want 2", pkt_count); end
    endtask

    task automatic test_seq_ovf();
        step(body(16'h1234), 1'b0);
        n_tests++; if (err_seq !== 1'b1 || rec_ack !== 1'b1) begin n_fail++; $display("FAIL seq_pulse got seq=%b ack=%b want 1 1", err_seq, rec_ack); end
        step(idle(), 1'b0);
        n_tests++; if (err_seq !== 1'b0) begin n_fail++; $display("FAIL seq_width got %b want 0", err_seq); end
        step(head(8'd3, 8'd3), 1'b0);
        for (int i = 0; i < MAX_BODY; i++) step(body(16'(i + 1)), 1'b0);
        n_tests++; if (err_ovf !== 1'b0 || pkt_len !== LW'(MAX_BODY)) begin n_fail++; $display("FAIL ovf_full got ovf=%b len=%0d want 0 %0d", err_ovf, pkt_len, MAX_BODY); end
        step(body(16'h0009), 1'b0);
        n_tests++; if (err_ovf !== 1'b1 || pkt_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_pulse got ovf=%b valid=%b want 1 0", err_ovf, pkt_valid); end
        step(idle(), 1'b0);
        n_tests++; if (err_ovf !== 1'b0 || pkt_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_after got ovf=%b valid=%b want 0 0", err_ovf, pkt_valid); end
    endtask

    task automatic test_hold();
        step(head(8'd3, 8'd3), 1'b0);
        step(body(16'h0005), 1'b0);
        step(tail(), 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(i == 2 ? body(16'h7777) : idle(), 1'b0);
            n_tests++; if (rec_ack !== 1'b0 || pkt_valid !== 1'b1 || pkt_len !== LW'(1) || pkt_sum !== 16'h0005 || err_seq !== 1'b0) begin
                n_fail++; $display("FAIL hold_stable cyc %0d got ack=%b valid=%b len=%0d sum=%h seq=%b want 0 1 1 0005 0", i, rec_ack, pkt_valid, pkt_len, pkt_sum, err_seq);
            end
        end
        step(idle(), 1'b1);
        n_tests++; if (pkt_count !== m_count || rec_ack !== 1'b1 || pkt_valid !== 1'b0) begin n_fail++; $display("FAIL hold_release got count=%0d ack=%b valid=%b want %0d 1 0", pkt_count, rec_ack, pkt_valid, m_count); end
    endtask

    task automatic test_timeout();
        step(head(8'd3, 8'd3), 1'b0);
        for (int i = 0; i < TMO - 1; i++) step(idle(), 1'b0);
        n_tests++; if (err_tmo !== 1'b0) begin n_fail++; $display("FAIL tmo_early got %b want 0", err_tmo); end
        step(idle(), 1'b0);
        n_tests++; if (err_tmo !== TMO_EN) begin n_fail++; $display("FAIL tmo_pulse got %b want %b", err_tmo, TMO_EN); end
        step(idle(), 1'b0);
        step(idle(), 1'b0);
        step(tail(), 1'b0);
        n_tests++; if (pkt_valid !== !TMO_EN || err_seq !== TMO_EN) begin n_fail++; $display("FAIL tmo_after got valid=%b seq=%b want %b %b", pkt_valid, err_seq, !TMO_EN, TMO_EN); end
        step(idle(), 1'b1);
        n_tests++; if (pkt_count !== m_count) begin n_fail++; $display("FAIL tmo_count got %0d want %0d", pkt_count, m_count); end
    endtask

    task automatic test_reset_mid();
        step(head(8'd3, 8'd3), 1'b0);
        step(body(16'h0007), 1'b0);
        do_reset();
        n_tests++; if ({pkt_valid, addr_err, err_seq, err_ovf, err_tmo, pkt_x, pkt_y, pkt_sum, pkt_count} !== '0 || pkt_len !== '0) begin
            n_fail++; $display("FAIL midrst_zero got valid=%b len=%0d sum=%h count=%0d want all zero", pkt_valid, pkt_len, pkt_sum, pkt_count);
        end
        reset_n = 1;
        n_tests++; if (rec_ack !== 1'b1) begin n_fail++; $display("FAIL midrst_ack got %b want 1", rec_ack); end
        step(head(8'd3, 8'd3), 1'b0);
        step(body(16'h0010), 1'b0);
        step(body(16'h0020), 1'b0);
        step(tail(), 1'b0);
        n_tests++; if (pkt_len !== LW'(2) || pkt_sum !== 16'h0030 || pkt_valid !== 1'b1) begin n_fail++; $display("FAIL midrst_pkt got len=%0d sum=%h valid=%b want 2 0030 1", pkt_len, pkt_sum, pkt_valid); end
        step(idle(), 1'b1);
        n_tests++; if (pkt_count !== 16'd1) begin n_fail++; $display("FAIL midrst_count got %0d want 1", pkt_count); end
    endtask

    task automatic test_random();
        FLIT_t f;
        int r;
        for (int c = 0; c < 3000; c++) begin
            r = int'($urandom_range(0, 99));
            f = mk($urandom_range(0, 4) != 0, r < 15 ? HEAD : r < 72 ? BODY : r < 88 ? TAIL : NONE,
                   $urandom_range(0, 1) ? 8'd3 : 8'($urandom_range(0, 255)),
                   $urandom_range(0, 1) ? 8'd3 : 8'($urandom_range(0, 255)), 16'($urandom));
            step(f, 1'($urandom_range(0, 1)));
            n_tests++; if ({rec_ack, pkt_valid, err_seq, err_ovf, err_tmo} !== {!m_hold, m_hold, e_seq, e_ovf, e_tmo}) begin
                n_fail++; $display("FAIL rnd_ctrl cyc %0d got ack/valid/seq/ovf/tmo=%b want %b", c, {rec_ack, pkt_valid, err_seq, err_ovf, err_tmo}, {!m_hold, m_hold, e_seq, e_ovf, e_tmo});
            end
            n_tests++; if (pkt_count !== m_count) begin n_fail++; $display("FAIL rnd_count cyc %0d got %0d want %0d", c, pkt_count, m_count); end
            if (m_hold) begin
                n_tests++; if (pkt_x !== m_x || pkt_y !== m_y || addr_err !== (m_x != 8'(MY_X) || m_y != 8'(MY_Y))) begin
                    n_fail++; $display("FAIL rnd_addr cyc %0d got x=%0d y=%0d err=%b want %0d %0d", c, pkt_x, pkt_y, addr_err, m_x, m_y);
                end
                n_tests++; if (pkt_len !== LW'(m_body.size()) || pkt_sum !== m_sum()) begin
                    n_fail++; $display("FAIL rnd_summary cyc %0d got len=%0d sum=%h want %0d %h", c, pkt_len, pkt_sum, m_body.size(), m_sum());
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap_addr_err();
        test_seq_ovf();
        test_hold();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/packet_receiver.md
PACKET_RECEIVER -- requirements
Module: packet_receiver

Interface
REQ-001 Parameter MY_X, default 3: local node x address, compared with the head xaddr.
REQ-002 Parameter MY_Y, default 3: local node y address, compared with the head yaddr.
REQ-003 Parameter MAX_BODY, default 8: maximum body flits per packet.
REQ-004 Parameter TIMEOUT_CYCLES, default 64: idle-cycle limit for the watchdog (REQ-021).
REQ-005 clk  in  1  clock; all logic on the rising edge.
REQ-006 reset_n  in  1  reset, asynchronous, active-low.
REQ-007 i_flit  in  FLIT_t  incoming flit (router_pkg); valid bit, flit_type (HEAD/BODY/TAIL/NONE), head xaddr/yaddr 8b, body data 16b.
REQ-008 i_rec_req  in  1  upstream request to deliver a packet.
REQ-009 o_rec_ack  out  1  receiver can accept flits.
REQ-010 o_pkt_valid  out  1  completed packet summary available.
REQ-011 i_pkt_ready  in  1  consumer accepts the summary.
REQ-012 o_pkt_xaddr, o_pkt_yaddr  out  8 each  head address of the delivered packet.
REQ-013 o_pkt_len  out  $clog2(MAX_BODY)+1  body flit count.
REQ-014 o_pkt_sum  out  16  modulo-2^16 sum of body data.
REQ-015 o_pkt_addr_err  out  1  head address != {MY_X,MY_Y}.
REQ-016 o_err_seq, o_err_ovf, o_err_tmo  out  1 each  single-cycle error pulses.
REQ-017 o_pkt_count  out  16  delivered-packet counter.

Function
REQ-018 FSM states: IDLE, RECV, HOLD; flits are sampled only when i_flit.valid=1 and o_rec_ack=1.
- o_rec_ack = 1 in IDLE and RECV; 0 in HOLD. The signal is a combinational decode of the state, independent of i_rec_req.
REQ-019 IDLE transitions:
- HEAD flit: latch xaddr/yaddr, clear len and sum, go to RECV.
- BODY or TAIL flit: pulse o_err_seq, drop the flit, stay in IDLE.
REQ-020 RECV transitions:
- BODY flit: sum += data (wraps at 2^16), len += 1.
- BODY flit arriving when len==MAX_BODY: pulse o_err_ovf, discard the packet, go to IDLE.
- HEAD flit: pulse o_err_seq, restart the packet from the new head and stay in RECV.
- TAIL flit: go to HOLD; a zero-body packet (len=0) is legal.
REQ-021 RECV watchdog: counts consecutive cycles with no valid flit; clears on every valid flit; resets on entry to RECV.
REQ-022 HOLD outputs: o_pkt_valid=1 starting the cycle after the TAIL is sampled (latency 1). Summary outputs and o_pkt_addr_err stay stable until the handshake completes.
REQ-023 HOLD exit: o_pkt_valid&&i_pkt_ready in a cycle -> o_pkt_count += 1 (wraps 0xFFFF->0), go to IDLE next cycle. i_pkt_ready while o_pkt_valid=0 has no effect.
REQ-024 HOLD flits: valid flits presented in HOLD are ignored and raise no error. Upstream must honour o_rec_ack.
REQ-025 Address mismatch: does not drop the packet; the packet is delivered with o_pkt_addr_err=1.
REQ-026 NONE-type or valid=0 flits: ignored in every state.
REQ-027 Error pulses: one cycle wide, registered, asserted the cycle after the offending flit is sampled.

Reset
REQ-028 On reset_n low: state=IDLE; o_pkt_valid=0; o_pkt_xaddr/yaddr/len/sum=0; o_pkt_addr_err=0; all error pulses=0; o_pkt_count=0; watchdog=0.
REQ-029 Reset mid-packet or in HOLD: the partial or pending packet is discarded with no error pulse. After release, o_rec_ack=1 on the first cycle.

Configuration
REQ-030 Macro PKT_RX_TIMEOUT_EN:
- Defined: when the watchdog reaches TIMEOUT_CYCLES in RECV, pulse o_err_tmo, discard the packet, go to IDLE.
- Undefined: no watchdog logic; RECV waits indefinitely; o_err_tmo is tied to 0.

Verification
REQ-031 HEAD(3,3), BODY 0x0001, BODY 0x0002, TAIL, i_pkt_ready=1 -> o_pkt_valid one cycle after TAIL, len=2, sum=0x0003, addr_err=0, o_pkt_count=1.
REQ-032 HEAD(1,2), BODY 0xFFFF, BODY 0x0002, TAIL -> sum=0x0001 (wrap), addr_err=1, packet still delivered.
REQ-033 BODY before any HEAD -> o_err_seq pulse, state stays IDLE. HEAD, 9 BODY flits with MAX_BODY=8 -> o_err_ovf on the 9th, no o_pkt_valid.
REQ-034 Packet held in HOLD with i_pkt_ready=0 for 5 cycles -> o_rec_ack=0 and outputs stable throughout; ready=1 -> count increments and ack returns next cycle.
REQ-035 PKT_RX_TIMEOUT_EN defined, TIMEOUT_CYCLES=4: HEAD then 4 idle cycles -> o_err_tmo pulse, return to IDLE. Same stimulus with the macro undefined -> remains in RECV.
REQ-036 reset_n low after HEAD and one BODY -> all outputs zero. Then a full packet after release -> delivered with len and sum from the new packet only.
